modbus_rtu_tx_framer: RTL
=========================

Name: modbus_rtu_tx_framer

Overview:
- Downstream of the AXI-Lite modbus register bank.
- Takes one request command (slave address, function code, 16-bit register address, 16-bit value/quantity) and computes CRC-16/MODBUS bit-serially.
- Streams the 8-byte RTU frame to the UART transmitter over a valid/ready byte interface.
- Then enforces an inter-frame silent gap before accepting the next command.

Parameters:
- GAP_CYCLES, 3500, idle clock cycles after the last byte before ready for the next command (t3.5 silence); min 1.
- CRC_INIT, 16'hFFFF, CRC preset value.
- CRC_POLY, 16'hA001, reflected polynomial for the LSB-first shift.

Ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request from the register bank.
- cmd_ready  out  1  framer can accept a command (state IDLE).
- cmd_slave  in  8  slave address byte.
- cmd_func  in  8  function code byte.
- cmd_addr  in  16  register start address (sent hi byte first).
- cmd_data  in  16  value or quantity (sent hi byte first).
- tx_data  out  8  frame byte to the UART.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART accepts the byte.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse when the last CRC byte is accepted.
- crc_out  out  16  CRC of the last frame, held until the next frame's CRC phase completes.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - State goes to IDLE. cmd_ready=1, tx_valid=0, tx_data=0, busy=0, frame_done=0, crc_out=0.
  - Internal byte index, bit counter and gap counter are cleared.
  - Reset mid-frame aborts the frame immediately. No further bytes are emitted and frame_done does not pulse.
- IDLE:
  - A handshake occurs when cmd_valid & cmd_ready at an edge (call it cycle 0).
  - That edge latches the six bytes into frame buffer b0..b5 = slave, func, addr[15:8], addr[7:0], data[15:8], data[7:0].
  - The CRC register is loaded with CRC_INIT and the state goes to CRC.
  - cmd_ready deasserts from cycle 1. Command inputs are ignored outside IDLE.
- CRC:
  - Byte k is XORed into crc[7:0] on its first bit cycle.
  - Then one bit per cycle, 8 cycles per byte, 48 cycles total: if crc[0], crc = (crc>>1)^CRC_POLY; else crc = crc>>1.
  - On completion (cycle 48), crc_out is updated and state goes to SEND with byte index 0.
  - tx_valid is first high in cycle 49.
- SEND:
  - Bytes are emitted in order b0..b5, crc[7:0], crc[15:8] (CRC low byte first).
  - tx_valid stays high and tx_data stays stable until tx_ready is seen.
  - On each accept, the index increments and the next byte is presented in the next cycle (back-to-back when tx_ready is held high, so 8 bytes take 8 cycles).
  - tx_ready while tx_valid=0 has no effect.
  - On accept of byte 7: tx_valid drops, frame_done pulses in the following cycle, state goes to GAP.
- GAP:
  - Counts GAP_CYCLES cycles with busy=1, cmd_ready=0, tx_valid=0, then returns to IDLE.
  - A cmd_valid held high during GAP is accepted on the first IDLE edge.
- Arithmetic:
  - All CRC operations are 16-bit, with no carry.
  - The byte index is 3 bits and wraps only via the state transition.
  - The gap counter is wide enough for GAP_CYCLES and saturates at terminal count.
- Simultaneous events: in IDLE with cmd_valid=1 and ARESET=1, reset wins and no command is latched.

Test Plan:
- Basic frame: cmd 01/03/0000/000A, tx_ready=1 -> bytes 01 03 00 00 00 0A C5 CD; crc_out=16'hCDC5; tx_valid first high 49 cycles after accept; frame_done one pulse.
- Second vector: cmd 01/06/0001/0003 -> bytes 01 06 00 01 00 03 98 0B; crc_out=16'h0B98.
- Backpressure: tx_ready random 30% duty -> each byte held stable until accepted; identical byte sequence to the basic-frame case; no duplicated or dropped bytes.
- Gap and back-to-back: GAP_CYCLES=10, cmd_valid held high -> second frame accepted exactly 10 cycles after the first frame_done cycle; cmd_ready=0 throughout the gap.
- Reset mid-frame: ARESET pulsed after byte 3 is accepted -> tx_valid=0 next cycle, no frame_done, cmd_ready=1; a new command then produces a correct full frame.
- Command ignored while busy: cmd_valid pulsed with different fields during CRC and SEND -> the in-flight frame is unchanged and the pulsed command is not latched.

Source files
------------

// File: rtl/modbus_rtu_tx_framer.sv
// -----------------------------------------------------------------------------
// modbus_rtu_tx_framer
//
// Builds one 8-byte Modbus RTU request frame from a command supplied by the
// register bank. It computes CRC-16/MODBUS one bit per clock, streams the frame
// bytes to the UART transmitter, and then holds off the next command for an
// inter-frame silent gap.
//
// Frame byte order on the wire:
//   slave, func, addr[15:8], addr[7:0], data[15:8], data[7:0],
//   crc[7:0], crc[15:8]
//
// Ports
//   ACLK        clock, rising edge
//   ARESET      synchronous active-high reset
//   cmd_valid   command request
//   cmd_ready   high while idle; a command is taken on valid & ready
//   cmd_slave   slave address byte
//   cmd_func    function code byte
//   cmd_addr    register start address, high byte sent first
//   cmd_data    value or quantity, high byte sent first
//   tx_data     byte to the UART
//   tx_valid    tx_data valid
//   tx_ready    UART accepts the byte
//   busy        high whenever the framer is not idle
//   frame_done  one-cycle pulse after the last CRC byte is accepted
//   crc_out     CRC of the most recent frame
// -----------------------------------------------------------------------------
module modbus_rtu_tx_framer #(
  parameter int unsigned GAP_CYCLES = 3500,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter logic [15:0] CRC_POLY   = 16'hA001
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_slave,
  input  logic [7:0]  cmd_func,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] crc_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CRC  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // The gap counter runs 0 .. GAP_CYCLES-1; one cycle is spent in GAP per count.
  localparam int unsigned    GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(GAP_CYCLES - 1);

  logic [1:0]       state_reg;
  logic [47:0]      frame_reg;      // b0 in [47:40] .. b5 in [7:0]
  logic [15:0]      crc_reg;
  logic [15:0]      crc_out_reg;
  logic [2:0]       byte_idx_reg;
  logic [2:0]       bit_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic             tx_valid_reg;
  logic [7:0]       tx_data_reg;
  logic             frame_done_reg;

  logic [7:0]       crc_byte_next;
  logic [15:0]      crc_mix_next;
  logic [15:0]      crc_next;

  // Byte i of the on-wire frame; indices 6 and 7 carry the CRC low byte first.
  function automatic logic [7:0] frame_byte(input logic [47:0] f,
                                            input logic [15:0] c,
                                            input logic [2:0]  i);
    logic [7:0] b;
    case (i)
      3'd0:    b = f[47:40];
      3'd1:    b = f[39:32];
      3'd2:    b = f[31:24];
      3'd3:    b = f[23:16];
      3'd4:    b = f[15:8];
      3'd5:    b = f[7:0];
      3'd6:    b = c[7:0];
      default: b = c[15:8];
    endcase
    return b;
  endfunction

  // One LSB-first CRC step. The data byte is folded into the low CRC byte only
  // on the first of its eight bit cycles.
  always_comb begin
    crc_byte_next = frame_byte(frame_reg, crc_out_reg, byte_idx_reg);
    crc_mix_next  = crc_reg;
    if (bit_cnt_reg == 3'd0) begin
      crc_mix_next = crc_reg ^ {8'h00, crc_byte_next};
    end
    if (crc_mix_next[0]) begin
      crc_next = (crc_mix_next >> 1) ^ CRC_POLY;
    end else begin
      crc_next = crc_mix_next >> 1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg      <= ST_IDLE;
      frame_reg      <= '0;
      crc_reg        <= '0;
      crc_out_reg    <= '0;
      byte_idx_reg   <= '0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      tx_data_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            frame_reg    <= {cmd_slave, cmd_func, cmd_addr, cmd_data};
            crc_reg      <= CRC_INIT;
            byte_idx_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= ST_CRC;
          end
        end

        ST_CRC: begin
          crc_reg     <= crc_next;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (byte_idx_reg == 3'd5) begin
              // Last bit of the last data byte: publish the CRC and present b0
              // straight away.
              crc_out_reg  <= crc_next;
              byte_idx_reg <= '0;
              tx_valid_reg <= 1'b1;
              tx_data_reg  <= frame_reg[47:40];
              state_reg    <= ST_SEND;
            end else begin
              byte_idx_reg <= byte_idx_reg + 3'd1;
            end
          end
        end

        ST_SEND: begin
          if (tx_valid_reg && tx_ready) begin
            if (byte_idx_reg == 3'd7) begin
              tx_valid_reg   <= 1'b0;
              frame_done_reg <= 1'b1;
              byte_idx_reg   <= '0;
              gap_cnt_reg    <= '0;
              state_reg      <= ST_GAP;
            end else begin
              byte_idx_reg <= byte_idx_reg + 3'd1;
              tx_data_reg  <= frame_byte(frame_reg, crc_out_reg, byte_idx_reg + 3'd1);
            end
          end
        end

        default: begin // ST_GAP
          if (gap_cnt_reg == GAP_TC) begin
            gap_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
      endcase
    end
  end

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign tx_valid   = tx_valid_reg;
  assign tx_data    = tx_data_reg;
  assign frame_done = frame_done_reg;
  assign crc_out    = crc_out_reg;

endmodule
